// File: rtl/tag_buffer_pkg.sv
// rtl/tag_buffer_pkg.sv - shared tag and sequence-number types for the rename tag free list
package tag_buffer_pkg;

  localparam int TAG_SIZE = 7;
  localparam int SQN_SIZE = 7;

  typedef logic [TAG_SIZE-1:0] Tag;
  typedef logic [SQN_SIZE-1:0] SqN;

  // Tags with the MSB set name the immediate/zero register and are never tracked.
  localparam Tag TAG_ZERO = Tag'(1 << (TAG_SIZE - 1));

  localparam int NUM_ISSUE  = 4;
  localparam int NUM_COMMIT = 4;
  localparam int NUM_TAGS   = 1 << (TAG_SIZE - 1);

endpackage

// File: rtl/tag_buffer_prio_enc.sv
// rtl/tag_buffer_prio_enc.sv - returns the COUNT lowest set-bit indices of a vector
module prio_enc_multi #(
  parameter int WIDTH = 64,
  parameter int COUNT = 4
) (
  input  logic [WIDTH-1:0]                       bits,
  output logic [COUNT-1:0][$clog2(WIDTH)-1:0]    idx,
  output logic [COUNT-1:0]                       valid
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] remaining;
  logic             found;

  // Peel off the lowest remaining set bit once per output slot.
  always_comb begin
    remaining = bits;
    idx       = '0;
    valid     = '0;
    found     = 1'b0;
    for (int k = 0; k < COUNT; k++) begin
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!found && remaining[i]) begin
          found  = 1'b1;
          idx[k] = IDX_W'(i);
        end
      end
      valid[k] = found;
      if (found) remaining[idx[k]] = 1'b0;
    end
  end

endmodule

// File: rtl/tag_buffer.sv
// rtl/tag_buffer.sv - physical tag free list: allocate at rename, free at commit and on mispredict
module tag_buffer
  import tag_buffer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          IN_mispred,
  input  SqN                            IN_mispredSqN,
  input  logic                          IN_mispredFlush,
  input  logic [NUM_ISSUE-1:0]          IN_issueValid,
  input  SqN   [NUM_ISSUE-1:0]          IN_issueSqN,
  output Tag   [NUM_ISSUE-1:0]          OUT_issueTags,
  output logic                          OUT_issueReady,
  input  logic [NUM_COMMIT-1:0]         IN_commitValid,
  input  Tag   [NUM_COMMIT-1:0]         IN_commitNewTag,
  input  Tag   [NUM_COMMIT-1:0]         IN_commitPrevTag
);

  localparam int IDX_W = TAG_SIZE - 1;
  localparam int CNT_W = $clog2(NUM_TAGS + 1);

  logic [NUM_TAGS-1:0]                used;
  logic [NUM_TAGS-1:0]                committed;
  SqN                                 sqn [NUM_TAGS];

  logic [NUM_TAGS-1:0]                free_vec;
  logic [NUM_TAGS-1:0]                squash;
  logic [NUM_ISSUE-1:0][IDX_W-1:0]    cand_idx;
  logic [NUM_ISSUE-1:0]               cand_valid;
  logic [CNT_W-1:0]                   free_count;

  assign free_vec = ~used;

  prio_enc_multi #(
    .WIDTH (NUM_TAGS),
    .COUNT (NUM_ISSUE)
  ) u_prio_enc (
    .bits  (free_vec),
    .idx   (cand_idx),
    .valid (cand_valid)
  );

  // Candidate tags per slot; the MSB is always clear since tracked tags never set it.
  always_comb begin
    for (int i = 0; i < NUM_ISSUE; i++) begin
      OUT_issueTags[i] = cand_valid[i] ? {1'b0, cand_idx[i]} : '0;
    end
  end

  // Free-tag popcount drives the ready flag.
  always_comb begin
    free_count = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      free_count = free_count + CNT_W'(free_vec[t]);
    end
    OUT_issueReady = (free_count >= CNT_W'(NUM_ISSUE));
  end

  // Tags owned by uncommitted ops younger than the branch; signed difference handles wrap.
  always_comb begin
    for (int t = 0; t < NUM_TAGS; t++) begin
      squash[t] = IN_mispred && used[t] && !committed[t] &&
                  ($signed(SqN'(sqn[t] - IN_mispredSqN)) > 0);
    end
  end

  // State update: allocate, then mark commits, then apply frees so a free beats a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used      <= '0;
      committed <= '0;
      for (int t = 0; t < NUM_TAGS; t++) sqn[t] <= '0;
    end else begin
      if (!IN_mispred) begin
        for (int i = 0; i < NUM_ISSUE; i++) begin
          if (IN_issueValid[i]) begin
            used[cand_idx[i]]      <= 1'b1;
            committed[cand_idx[i]] <= 1'b0;
            sqn[cand_idx[i]]       <= IN_issueSqN[i];
          end
        end
      end
      if (!IN_mispredFlush) begin
        for (int j = 0; j < NUM_COMMIT; j++) begin
          if (IN_commitValid[j] && !IN_commitNewTag[j][TAG_SIZE-1])
            committed[IN_commitNewTag[j][IDX_W-1:0]] <= 1'b1;
        end
      end
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (squash[t]) begin
          used[t]      <= 1'b0;
          committed[t] <= 1'b0;
        end
      end
      if (!IN_mispredFlush) begin
        for (int j = 0; j < NUM_COMMIT; j++) begin
          if (IN_commitValid[j] && !IN_commitPrevTag[j][TAG_SIZE-1]) begin
            used[IN_commitPrevTag[j][IDX_W-1:0]]      <= 1'b0;
            committed[IN_commitPrevTag[j][IDX_W-1:0]] <= 1'b0;
          end
        end
      end
    end
  end

  // Protocol checks: no issue without enough free tags, no commit touching a free tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(|IN_issueValid) || OUT_issueReady)
        else $error("tag_buffer: issue while not ready");
      if (!IN_mispredFlush) begin
        for (int j = 0; j < NUM_COMMIT; j++) begin
          if (IN_commitValid[j]) begin
            assert (IN_commitNewTag[j][TAG_SIZE-1] || used[IN_commitNewTag[j][IDX_W-1:0]])
              else $error("tag_buffer: commit new tag %0d is free", IN_commitNewTag[j]);
            assert (IN_commitPrevTag[j][TAG_SIZE-1] || used[IN_commitPrevTag[j][IDX_W-1:0]])
              else $error("tag_buffer: commit prev tag %0d is free", IN_commitPrevTag[j]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tag_buffer.sv
// tb/tb_tag_buffer.sv - directed self-checking bench for tag_buffer
module tb_tag_buffer;
  import tag_buffer_pkg::*;

  logic                   clk;
  logic                   rst;
  logic                   IN_mispred;
  SqN                     IN_mispredSqN;
  logic                   IN_mispredFlush;
  logic [NUM_ISSUE-1:0]   IN_issueValid;
  SqN   [NUM_ISSUE-1:0]   IN_issueSqN;
  Tag   [NUM_ISSUE-1:0]   OUT_issueTags;
  logic                   OUT_issueReady;
  logic [NUM_COMMIT-1:0]  IN_commitValid;
  Tag   [NUM_COMMIT-1:0]  IN_commitNewTag;
  Tag   [NUM_COMMIT-1:0]  IN_commitPrevTag;

  int tests;
  int failed;

  tag_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .IN_mispred       (IN_mispred),
    .IN_mispredSqN    (IN_mispredSqN),
    .IN_mispredFlush  (IN_mispredFlush),
    .IN_issueValid    (IN_issueValid),
    .IN_issueSqN      (IN_issueSqN),
    .OUT_issueTags    (OUT_issueTags),
    .OUT_issueReady   (OUT_issueReady),
    .IN_commitValid   (IN_commitValid),
    .IN_commitNewTag  (IN_commitNewTag),
    .IN_commitPrevTag (IN_commitPrevTag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
      end
  endtask

  task automatic check_slots(input string name, input int n,
                             input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < n; k++)
      check($sformatf("%s_slot%0d", name, k), 32'(OUT_issueTags[k]), e[k]);
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        check($sformatf("%s_distinct%0d%0d", name, a, b),
              32'(OUT_issueTags[a] != OUT_issueTags[b]), 1);
  endtask

  task automatic idle();
    IN_mispred       = 1'b0;
    IN_mispredSqN    = '0;
    IN_mispredFlush  = 1'b0;
    IN_issueValid    = '0;
    IN_issueSqN      = '0;
    IN_commitValid   = '0;
    IN_commitNewTag  = '0;
    IN_commitPrevTag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [NUM_ISSUE-1:0] mask, input int base);
    IN_issueValid = mask;
    for (int i = 0; i < NUM_ISSUE; i++) IN_issueSqN[i] = SqN'(base + i);
    tick();
    idle();
  endtask

  task automatic commit1(input int port, input Tag new_tag, input Tag prev_tag, input logic flush);
    IN_commitValid[port]   = 1'b1;
    IN_commitNewTag[port]  = new_tag;
    IN_commitPrevTag[port] = prev_tag;
    IN_mispredFlush        = flush;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state and idle stability
    check_slots("t1_inreset", 4, 0, 1, 2, 3);
    check("t1_ready_inreset", 32'(OUT_issueReady), 1);
    rst = 1'b0;
    tick();
    check_slots("t1_idle", 4, 0, 1, 2, 3);
    check("t1_ready_idle", 32'(OUT_issueReady), 1);

    // 2: allocate four tags with sqN 10..13
    issue(4'hF, 10);
    check_slots("t2_alloc", 4, 4, 5, 6, 7);
    check("t2_ready", 32'(OUT_issueReady), 1);

    // 3: commit without a prev tag, then commit freeing tag 0
    commit1(0, Tag'(0), TAG_ZERO, 1'b0);
    check_slots("t3_nofree", 4, 4, 5, 6, 7);
    commit1(0, Tag'(1), Tag'(0), 1'b0);
    check_slots("t3_free0", 4, 0, 4, 5, 6);

    // 4: mid-operation reset, then mispredict squashing younger ops
    rst = 1'b1;
    #1;
    check_slots("t4_async_rst", 4, 0, 1, 2, 3);
    tick();
    rst = 1'b0;
    issue(4'hF, 10);
    check_slots("t4_alloc", 4, 4, 5, 6, 7);
    IN_mispred    = 1'b1;
    IN_mispredSqN = SqN'(11);
    IN_issueValid = 4'hF;
    for (int i = 0; i < NUM_ISSUE; i++) IN_issueSqN[i] = SqN'(20 + i);
    tick();
    idle();
    check_slots("t4_mispred", 4, 2, 3, 4, 5);

    // 5: sequence-number wrap-around
    do_reset();
    IN_issueValid  = 4'b0011;
    IN_issueSqN[0] = SqN'((1 << SQN_SIZE) - 1);
    IN_issueSqN[1] = SqN'(1);
    tick();
    idle();
    check_slots("t5_alloc", 4, 2, 3, 4, 5);
    IN_mispred    = 1'b1;
    IN_mispredSqN = SqN'((1 << SQN_SIZE) - 2);
    tick();
    idle();
    check_slots("t5_both_freed", 4, 0, 1, 2, 3);
    IN_issueValid  = 4'b0011;
    IN_issueSqN[0] = SqN'((1 << SQN_SIZE) - 1);
    IN_issueSqN[1] = SqN'(1);
    tick();
    idle();
    IN_mispred    = 1'b1;
    IN_mispredSqN = SqN'(0);
    tick();
    idle();
    check_slots("t5_one_freed", 4, 1, 2, 3, 4);

    // 7: committed tags survive a mispredict; same-cycle commit applies; flushed commits ignored
    do_reset();
    issue(4'hF, 40);
    commit1(0, Tag'(3), TAG_ZERO, 1'b0);
    check_slots("t7_commit3", 4, 4, 5, 6, 7);
    IN_mispred         = 1'b1;
    IN_mispredSqN      = SqN'(40);
    IN_commitValid[0]  = 1'b1;
    IN_commitNewTag[0] = Tag'(0);
    IN_commitPrevTag[0] = TAG_ZERO;
    tick();
    idle();
    check_slots("t7_mispred", 4, 1, 2, 4, 5);
    IN_mispred          = 1'b1;
    IN_mispredSqN       = SqN'(50);
    IN_mispredFlush     = 1'b1;
    IN_commitValid[0]   = 1'b1;
    IN_commitNewTag[0]  = Tag'(3);
    IN_commitPrevTag[0] = Tag'(0);
    tick();
    idle();
    check_slots("t7_flush", 4, 1, 2, 4, 5);

    // 6: exhaustion boundary and flushed vs real commit
    do_reset();
    for (int c = 0; c < 15; c++) issue(4'hF, c * 4);
    check_slots("t6_four_left", 4, 60, 61, 62, 63);
    check("t6_ready_four", 32'(OUT_issueReady), 1);
    issue(4'b0001, 100);
    check("t6_ready_three", 32'(OUT_issueReady), 0);
    check_slots("t6_three", 3, 61, 62, 63, 0);
    commit1(0, Tag'(5), Tag'(0), 1'b1);
    check("t6_ready_flush", 32'(OUT_issueReady), 0);
    check_slots("t6_flush", 3, 61, 62, 63, 0);
    commit1(0, Tag'(5), Tag'(0), 1'b0);
    check("t6_ready_commit", 32'(OUT_issueReady), 1);
    check_slots("t6_commit", 4, 0, 61, 62, 63);
    IN_commitValid      = 4'b0011;
    IN_commitNewTag[0]  = Tag'(7);
    IN_commitPrevTag[0] = TAG_ZERO;
    IN_commitNewTag[1]  = TAG_ZERO;
    IN_commitPrevTag[1] = Tag'(7);
    tick();
    idle();
    check_slots("t6_free_wins", 4, 0, 7, 61, 62);
    check("t6_ready_end", 32'(OUT_issueReady), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tag_buffer.md
Name: tag_buffer

Overview:
- Physical-tag free list for the rename stage. It is the allocator and reclaimer for the tags the rename table maps architectural registers to.
- Hands out up to NUM_ISSUE fresh tags per cycle to renaming ops.
- Marks a tag committed when its producer retires, and frees the displaced previous tag returned by the rename table at commit.
- On mispredict, reclaims tags allocated by ops younger than the branch.

Parameters:
NUM_ISSUE, 4, tags offered per cycle
NUM_COMMIT, 4, commit ports
NUM_TAGS, 64, tracked physical tags (= 1 << (TAG_SIZE-1))
TAG_SIZE, $bits(Tag), tag width; MSB set = immediate/zero tag, never tracked
SQN_SIZE, $bits(SqN), ROB sequence number width

Ports:
clk  in  1  clock
rst  in  1  reset
IN_mispred  in  1  mispredict this cycle
IN_mispredSqN  in  SQN_SIZE  sqN of mispredicted branch; ops strictly younger are squashed
IN_mispredFlush  in  1  ROB replay window after mispredict
IN_issueValid  in  1 x NUM_ISSUE  slot i consumes OUT_issueTags[i]
IN_issueSqN  in  SQN_SIZE x NUM_ISSUE  sqN of op in slot i
OUT_issueTags  out  TAG_SIZE x NUM_ISSUE  candidate free tag per slot, MSB always 0
OUT_issueReady  out  1  at least NUM_ISSUE tags free
IN_commitValid  in  1 x NUM_COMMIT  commit entry valid (only for ops with a register destination)
IN_commitNewTag  in  TAG_SIZE x NUM_COMMIT  tag written by committing op
IN_commitPrevTag  in  TAG_SIZE x NUM_COMMIT  tag displaced by commit (rename table prev tag)

Behaviour:
- Reset is asynchronous, active-high (rst), clock clk.
- Per-tag state: used, committed, sqN[SQN_SIZE].
- Reset state: all tags have used=0 and committed=0.
- Reset outputs: OUT_issueTags[i]=i; OUT_issueReady=1.
- Reset mid-operation discards everything; all tags become free.
- Candidate selection (combinational from registered state): OUT_issueTags[i] = i-th lowest-index tag with used=0.
  - Candidates are fixed per slot, independent of which IN_issueValid bits are set.
  - Unconsumed candidates stay free.
- OUT_issueReady = (popcount of free tags >= NUM_ISSUE).
- Issuing with OUT_issueReady=0 is a protocol violation; simulation asserts it.
- Allocation, with no mispredict: for each valid slot i, the candidate tag gets used<=1, committed<=0, sqN<=IN_issueSqN[i].
  - Visible on outputs the next cycle (1-cycle latency).
- Commit, only when IN_mispredFlush=0: for each valid port j:
  - If NewTag MSB=0: committed[NewTag]<=1.
  - If PrevTag MSB=0: used[PrevTag]<=0 and committed[PrevTag]<=0.
  - Freed tags become candidates next cycle; there is no same-cycle bypass into allocation.
- Commit with IN_mispredFlush=1: ignored entirely. These are ROB replays of already-tracked state.
- Mispredict:
  - All issue allocations that cycle are dropped.
  - Every tag with used=1, committed=0 and (sqN - IN_mispredSqN) interpreted as signed SQN_SIZE > 0 is freed. The signed compare handles wrap-around.
  - Tags at or older than the branch sqN are kept.
  - Commits in the same cycle are still applied when IN_mispredFlush=0; committing ops are older than the branch.
- Free vs commit on the same tag in the same cycle: free wins.
- Commit of a tag that is already free: simulation asserts. Commit of a tag already committed: harmless.
- Allocation can never select a tag freed in the same cycle, because that tag is still used in the current state.
- Invariant (bench checks): free count + used count == NUM_TAGS; no tag appears in two OUT_issueTags slots.

Decomposition:
- Shared package: Tag, SqN typedefs; TAG_SIZE, SQN_SIZE, TAG_ZERO constants.
- Sub-module: prio_enc_multi (parameterised; returns lowest NUM_ISSUE set-bit indices plus valid flags from a NUM_TAGS vector). The free-count popcount stays inline.

Test Plan:
1. Reset release, no stimulus -> OUT_issueTags={0,1,2,3}, OUT_issueReady=1; next cycle unchanged.
2. All 4 slots valid, sqN 10..13 -> next cycle OUT_issueTags={4,5,6,7}; tags 0-3 used with sqN 10-13.
3. After 2, commit NewTag=0, PrevTag=TAG_ZERO (MSB set) -> tag 0 committed, no tag freed. Then commit NewTag=1, PrevTag=0 -> next cycle tag 0 is candidate slot 0 again.
4. Allocate tags 0-3 with sqN 10-13, then IN_mispred with SqN=11 together with 4 valid issues -> tags 2,3 freed, tags 0,1 kept, no new allocation; next cycle OUT_issueTags={2,3,4,5}.
5. Wrap-around: tags allocated with sqN 2^SQN_SIZE-1 and 1; mispred SqN=2^SQN_SIZE-2 -> both freed. Mispred SqN=0 -> only the sqN=1 tag freed.
6. Allocate until 3 tags remain -> OUT_issueReady=0. Commit freeing 1 tag with IN_mispredFlush=1 -> still 0. Same commit with IN_mispredFlush=0 -> OUT_issueReady=1 next cycle.
